// File: rtl/button_gesture.sv
// Classifies debounced button presses into single click, double click and long press pulses.
// Optional auto-repeat while held: define BUTTON_GESTURE_AUTOREPEAT_EN.
module button_gesture #(
  parameter int CLK_PERIOD_NS = 10,
  parameter int LONG_PRESS_MS = 500,
  parameter int DOUBLE_GAP_MS = 250,
  parameter int REPEAT_MS     = 100
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clean_in,
  output logic       press_out,
  output logic       release_out,
  output logic       single_out,
  output logic       double_out,
  output logic       long_out,
  output logic       repeat_out,
  output logic [2:0] state_out
);

  localparam int TICKS_PER_MS = 1_000_000 / CLK_PERIOD_NS;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MAX_LD = (LONG_PRESS_MS > DOUBLE_GAP_MS) ? LONG_PRESS_MS : DOUBLE_GAP_MS;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
  localparam int MS_MAX = (REPEAT_MS > MAX_LD) ? REPEAT_MS : MAX_LD;
`else
  // Repeat interval must not widen the counter when auto-repeat is off.
  localparam int MS_MAX = MAX_LD + (REPEAT_MS * 0);
`endif
  localparam int MW = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;

  localparam logic [MW-1:0] LONG_TH = MW'(LONG_PRESS_MS);
  localparam logic [MW-1:0] GAP_TH  = MW'(DOUBLE_GAP_MS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRESS1 = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] PRESS2 = 3'd3;
  localparam logic [2:0] HELD   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [MW-1:0] ms_q, ms_inc;
  logic          prev_q;
  logic          ms_tick, rise, fall, clr;
  logic          long_hit, gap_hit;
  logic          press_d, release_d, single_d, double_d, long_d;

  assign ms_tick = (presc_q == PW'(TICKS_PER_MS - 1));
  assign ms_inc  = (ms_q == '1) ? ms_q : ms_q + MW'(1);
  assign rise    = clean_in & ~prev_q;
  assign fall    = ~clean_in & prev_q;

  // Timeouts fire on the tick that steps the counter onto the threshold,
  // so a pulse lands exactly N ms after the state was entered.
  assign long_hit = ms_tick && (ms_inc == LONG_TH);
  assign gap_hit  = ms_tick && (ms_inc == GAP_TH);

`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
  localparam logic [MW-1:0] REP_TH = MW'(REPEAT_MS);
  logic rep_hit, repeat_d, repeat_q;
  assign rep_hit = ms_tick && (ms_inc == REP_TH);
`endif

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    clr       = 1'b0;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_d   = GAP;
          release_d = 1'b1;
        end else if (long_hit) begin
          state_d = HELD;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_d = PRESS2;
          press_d = 1'b1;
        end else if (gap_hit) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (long_hit) begin
          state_d = HELD;
          long_d  = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
        else if (rep_hit) begin
          repeat_d = 1'b1;
          clr      = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) clr = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      ms_q        <= '0;
      prev_q      <= 1'b1;
      press_out   <= 1'b0;
      release_out <= 1'b0;
      single_out  <= 1'b0;
      double_out  <= 1'b0;
      long_out    <= 1'b0;
    end else begin
      prev_q      <= clean_in;
      state_q     <= state_d;
      press_out   <= press_d;
      release_out <= release_d;
      single_out  <= single_d;
      double_out  <= double_d;
      long_out    <= long_d;
      if (clr) begin
        presc_q <= '0;
        ms_q    <= '0;
      end else if (ms_tick) begin
        presc_q <= '0;
        ms_q    <= ms_inc;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) repeat_q <= 1'b0;
    else         repeat_q <= repeat_d;
  end
  assign repeat_out = repeat_q;
`else
  assign repeat_out = 1'b0;
`endif

  assign state_out = state_q;

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture at 10 ticks/ms, long=5ms, gap=3ms, repeat=2ms.
module tb_button_gesture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clean = 1'b0;
  logic       press_o, release_o, single_o, double_o, long_o, repeat_o;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // pulse monitor slots: 0 press, 1 release, 2 single, 3 double, 4 long, 5 repeat
  int n[6];
  int last[6];
  int rep_cyc[4];

  button_gesture #(
    .CLK_PERIOD_NS(100_000),
    .LONG_PRESS_MS(5),
    .DOUBLE_GAP_MS(3),
    .REPEAT_MS(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .clean_in(clean),
    .press_out(press_o),
    .release_out(release_o),
    .single_out(single_o),
    .double_out(double_o),
    .long_out(long_o),
    .repeat_out(repeat_o),
    .state_out(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] v;
    v = {repeat_o, long_o, double_o, single_o, release_o, press_o};
    for (int i = 0; i < 6; i++) begin
      if (v[i]) begin
        if (i == 5 && n[5] < 4) rep_cyc[n[5]] = cyc;
        n[i]++;
        last[i] = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_mon();
    for (int i = 0; i < 6; i++) begin
      n[i] = 0;
      last[i] = -1;
    end
    for (int i = 0; i < 4; i++) rep_cyc[i] = -1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // drive so that the posedge numbered t samples the new level
  task automatic drive_at(input logic v, input int t);
    wait_until(t - 1);
    clean = v;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clean = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    checks++;
    if ({repeat_o, long_o, double_o, single_o, release_o, press_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 000000",
               {repeat_o, long_o, double_o, single_o, release_o, press_o});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    @(negedge clk);
    clr_mon();
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    drive_at(1'b0, t0 + 20);
    wait_until(t0 + 120);
    checks++; if (n[0] !== 1)       begin errors++; $display("FAIL single_press_cnt: got %0d expected 1", n[0]); end
    checks++; if (last[0] !== t0)   begin errors++; $display("FAIL single_press_cyc: got %0d expected %0d", last[0], t0); end
    checks++; if (last[1] !== t0+20) begin errors++; $display("FAIL single_release_cyc: got %0d expected %0d", last[1], t0+20); end
    checks++; if (n[2] !== 1)       begin errors++; $display("FAIL single_cnt: got %0d expected 1", n[2]); end
    checks++; if (last[2] !== t0+50) begin errors++; $display("FAIL single_cyc: got %0d expected %0d", last[2], t0+50); end
    checks++; if (n[3] + n[4] !== 0) begin errors++; $display("FAIL single_no_dbl_long: got %0d expected 0", n[3]+n[4]); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL single_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_double();
    int t0;
    @(negedge clk);
    clr_mon();
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    drive_at(1'b0, t0 + 20);
    drive_at(1'b1, t0 + 35);
    drive_at(1'b0, t0 + 55);
    wait_until(t0 + 120);
    checks++; if (n[0] !== 2)        begin errors++; $display("FAIL double_press_cnt: got %0d expected 2", n[0]); end
    checks++; if (last[0] !== t0+35) begin errors++; $display("FAIL double_press2_cyc: got %0d expected %0d", last[0], t0+35); end
    checks++; if (last[1] !== t0+55) begin errors++; $display("FAIL double_release_cyc: got %0d expected %0d", last[1], t0+55); end
    checks++; if (n[3] !== 1)        begin errors++; $display("FAIL double_cnt: got %0d expected 1", n[3]); end
    checks++; if (last[3] !== t0+55) begin errors++; $display("FAIL double_cyc: got %0d expected %0d", last[3], t0+55); end
    checks++; if (n[2] + n[4] !== 0) begin errors++; $display("FAIL double_no_single_long: got %0d expected 0", n[2]+n[4]); end
  endtask

  task automatic test_long();
    int t0;
    @(negedge clk);
    clr_mon();
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    wait_until(t0 + 79);
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL long_state_held: got %0d expected 4", state_o); end
    drive_at(1'b0, t0 + 80);
    wait_until(t0 + 100);
    checks++; if (n[4] !== 1)        begin errors++; $display("FAIL long_cnt: got %0d expected 1", n[4]); end
    checks++; if (last[4] !== t0+50) begin errors++; $display("FAIL long_cyc: got %0d expected %0d", last[4], t0+50); end
    checks++; if (last[1] !== t0+80) begin errors++; $display("FAIL long_release_cyc: got %0d expected %0d", last[1], t0+80); end
    checks++; if (n[2] + n[3] !== 0) begin errors++; $display("FAIL long_no_single_dbl: got %0d expected 0", n[2]+n[3]); end
    checks++; if (state_o !== 3'd0)  begin errors++; $display("FAIL long_state_idle: got %0d expected 0", state_o); end
  endtask

  task automatic test_boundary();
    int t0;
    @(negedge clk);
    clr_mon();
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    drive_at(1'b0, t0 + 50);
    wait_until(t0 + 50);
    checks++; if ({release_o, long_o} !== 2'b10) begin errors++; $display("FAIL bnd_release_vs_long: got %b expected 10", {release_o, long_o}); end
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL bnd_state_gap: got %0d expected 2", state_o); end
    drive_at(1'b1, t0 + 80);
    wait_until(t0 + 80);
    checks++; if ({press_o, single_o} !== 2'b10) begin errors++; $display("FAIL bnd_press_vs_single: got %b expected 10", {press_o, single_o}); end
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL bnd_state_press2: got %0d expected 3", state_o); end
    drive_at(1'b0, t0 + 90);
    wait_until(t0 + 130);
    checks++; if (n[2] + n[4] !== 0) begin errors++; $display("FAIL bnd_no_single_long: got %0d expected 0", n[2]+n[4]); end
    checks++; if (last[3] !== t0+90) begin errors++; $display("FAIL bnd_double_cyc: got %0d expected %0d", last[3], t0+90); end
  endtask

  task automatic test_reset_mid();
    int t0;
    int tot;
    @(negedge clk);
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    wait_until(t0 + 5);
    clr_mon();
    wait_until(t0 + 9);
    rst_n = 1'b0;
    wait_until(t0 + 11);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rstmid_state_in_reset: got %0d expected 0", state_o); end
    wait_until(t0 + 12);
    rst_n = 1'b1;
    drive_at(1'b0, t0 + 30);
    wait_until(t0 + 80);
    tot = n[0] + n[1] + n[2] + n[3] + n[4] + n[5];
    checks++; if (tot !== 0)        begin errors++; $display("FAIL rstmid_no_pulses: got %0d expected 0", tot); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rstmid_state_idle: got %0d expected 0", state_o); end
    drive_at(1'b1, t0 + 90);
    wait_until(t0 + 90);
    checks++; if ({press_o, state_o} !== 4'b1001) begin errors++; $display("FAIL rstmid_fresh_press: got %b expected 1001", {press_o, state_o}); end
    drive_at(1'b0, t0 + 95);
    wait_until(t0 + 140);
  endtask

  task automatic test_repeat();
    int t0;
    @(negedge clk);
    clr_mon();
    t0 = cyc + 2;
    drive_at(1'b1, t0);
    drive_at(1'b0, t0 + 120);
    wait_until(t0 + 140);
    chk("rep_long_cyc", last[4], t0 + 50);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
    chk("rep_cnt", n[5], 3);
    chk("rep_first", rep_cyc[0], t0 + 70);
    chk("rep_second", rep_cyc[1], t0 + 90);
    chk("rep_third", rep_cyc[2], t0 + 110);
`else
    chk("rep_cnt_off", n[5], 0);
`endif
    chk("rep_release_cyc", last[1], t0 + 120);
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_single();
    test_double();
    test_long();
    test_boundary();
    test_reset_mid();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
